// File: rtl/fsmc_fifo_bridge_if.sv
// rtl/fsmc_fifo_bridge_if.sv - FSMC register bus and local stream signals of the FIFO bridge
interface fsmc_fifo_bridge_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  cs;
    logic                  state;
    logic [DATA_WIDTH-1:0] bus_data;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output cs, state, bus_data, tx_ready, rx_data, rx_valid,
        input  wr_data, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  cs, state, bus_data, tx_ready, rx_data, rx_valid,
        output wr_data, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/fsmc_fifo_bridge.sv
// rtl/fsmc_fifo_bridge.sv - FSMC register window onto a down FIFO (MCU->FPGA) and an up FIFO (FPGA->MCU)
module fsmc_fifo_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    fsmc_fifo_bridge_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ADDR} fsm_t;

    fsm_t                  st_q, st_d;
    logic                  cs_q;
    logic [1:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [PW-1:0]         dn_wp_q, dn_wp_d, dn_rp_q, dn_rp_d;
    logic [PW-1:0]         up_wp_q, up_wp_d, up_rp_q, up_rp_d;
    logic [CW-1:0]         dn_cnt_q, dn_cnt_d, up_cnt_q, up_cnt_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;

    // Storage is deliberately outside the reset domain; only pointers and counts reset.
    logic [DATA_WIDTH-1:0] dn_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] up_mem [FIFO_DEPTH];

    logic dn_full, dn_empty, up_full, up_empty;
    logic mcu_wr, mcu_pop, ctrl_wr;
    logic dn_push, dn_pop, up_push, up_pop;
    logic [DATA_WIDTH-1:0] status;

    assign dn_full  = (dn_cnt_q == CW'(FIFO_DEPTH));
    assign dn_empty = (dn_cnt_q == '0);
    assign up_full  = (up_cnt_q == CW'(FIFO_DEPTH));
    assign up_empty = (up_cnt_q == '0);

    always_comb begin
        status      = '0;
        status[0]   = dn_full;
        status[1]   = dn_empty;
        status[2]   = up_full;
        status[3]   = up_empty;
        status[8:4] = 5'(up_cnt_q);
        status[9]   = ovf_q;
        status[10]  = udf_q;
    end

    always_comb begin
        st_d      = st_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        mcu_wr    = 1'b0;
        mcu_pop   = 1'b0;
        case (st_q)
            IDLE: begin
                if (bus.cs && !cs_q) begin
                    st_d   = ADDR;
                    addr_d = bus.bus_data[1:0];
                    // Read-back word is frozen at address latch so the MCU sees a stable value.
                    case (addr_d)
                        2'd1:    wr_data_d = up_empty ? '0 : up_mem[up_rp_q];
                        2'd2:    wr_data_d = status;
                        default: wr_data_d = '0;
                    endcase
                end
            end
            ADDR: begin
                if (!bus.cs && cs_q) begin
                    st_d = IDLE;
                    if (!bus.state)
                        mcu_wr = 1'b1;
                    else if (addr_q == 2'd1)
                        mcu_pop = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_wr  = mcu_wr && (addr_q == 2'd2);
        dn_push  = mcu_wr && (addr_q == 2'd0) && !dn_full;
        dn_pop   = !dn_empty && bus.tx_ready;
        up_push  = bus.rx_valid && !up_full;
        up_pop   = mcu_pop && !up_empty;

        ovf_d = ovf_q;
        udf_d = udf_q;
        if (ctrl_wr && bus.bus_data[2]) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (mcu_wr && (addr_q == 2'd0) && dn_full) ovf_d = 1'b1;
        if (mcu_pop && up_empty) udf_d = 1'b1;

        dn_wp_d  = dn_push ? dn_wp_q + PW'(1) : dn_wp_q;
        dn_rp_d  = dn_pop  ? dn_rp_q + PW'(1) : dn_rp_q;
        dn_cnt_d = dn_cnt_q + CW'(dn_push) - CW'(dn_pop);
        if (ctrl_wr && bus.bus_data[0]) begin
            dn_wp_d  = '0;
            dn_rp_d  = '0;
            dn_cnt_d = '0;
        end

        up_wp_d  = up_push ? up_wp_q + PW'(1) : up_wp_q;
        up_rp_d  = up_pop  ? up_rp_q + PW'(1) : up_rp_q;
        up_cnt_d = up_cnt_q + CW'(up_push) - CW'(up_pop);
        if (ctrl_wr && bus.bus_data[1]) begin
            up_wp_d  = '0;
            up_rp_d  = '0;
            up_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q      <= IDLE;
            cs_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            dn_wp_q   <= '0;
            dn_rp_q   <= '0;
            dn_cnt_q  <= '0;
            up_wp_q   <= '0;
            up_rp_q   <= '0;
            up_cnt_q  <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            cs_q      <= bus.cs;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            dn_wp_q   <= dn_wp_d;
            dn_rp_q   <= dn_rp_d;
            dn_cnt_q  <= dn_cnt_d;
            up_wp_q   <= up_wp_d;
            up_rp_q   <= up_rp_d;
            up_cnt_q  <= up_cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dn_push) dn_mem[dn_wp_q] <= bus.bus_data;
        if (up_push) up_mem[up_wp_q] <= bus.rx_data;
    end

    assign bus.wr_data  = wr_data_q;
    assign bus.tx_data  = dn_mem[dn_rp_q];
    assign bus.tx_valid = !dn_empty;
    assign bus.rx_ready = !up_full;
endmodule
